// File: rtl/watchdog_pkg.sv
// Shared constants and elaboration-time helpers for the bus watchdog.
`timescale 1ns/1ps
package watchdog_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 100;

  // Smallest r with 2**r >= v, never below 1 so a counter keeps at least one bit.
  function automatic int unsigned wd_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/watchdog_if.sv
// Link between the saturating counter and the bus-error flag register.
`timescale 1ns/1ps
interface watchdog_if
  import watchdog_pkg::*;
#(
  parameter int unsigned CNT_W = wd_clog2(TIMEOUT_DEFAULT + 1)
);

  logic [CNT_W-1:0] cnt;
  logic             tc_next;

  modport master (output cnt, tc_next);
  modport slave  (input  cnt, tc_next);

endinterface

// File: rtl/watchdog_counter.sv
// Saturating up-counter with asynchronous clear; flags when the next edge lands on TIMEOUT.
`timescale 1ns/1ps
module watchdog_counter
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = wd_clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          clr,
  watchdog_if.master    cnt_if
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != TC) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Stays asserted once saturated, since cnt_d then equals TC as well.
  assign cnt_if.cnt     = cnt_q;
  assign cnt_if.tc_next = (cnt_d == TC);

endmodule

// File: rtl/watchdog.sv
// Bus watchdog: berr_n drops, and latches low, on the TIMEOUT-th clk edge after clr releases.
`timescale 1ns/1ps
module watchdog
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = wd_clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic clr,
  output logic berr_n
);

  watchdog_if #(.CNT_W(CNT_W)) cnt_if ();

  watchdog_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk    (clk),
    .clr    (clr),
    .cnt_if (cnt_if)
  );

  logic berr_n_q = 1'b1;
  logic berr_n_d;

  // Decoded from the counter's next value so the flag falls on the same edge cnt reaches TIMEOUT.
  always_comb begin
    berr_n_d = berr_n_q & ~cnt_if.tc_next;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) berr_n_q <= 1'b1;
    else     berr_n_q <= berr_n_d;
  end

  assign berr_n = berr_n_q;

endmodule

// File: tb/tb_watchdog.sv
// Scoreboard bench for watchdog: stimulus queues expected berr_n/cnt, a monitor compares.
`timescale 1ns/1ps
module tb_watchdog;
  import watchdog_pkg::*;

  typedef struct packed {
    logic [63:0] tag;
    logic        dut2;
    logic        exp_berr;
    logic [15:0] exp_cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic clr  = 1'b0;
  logic clr2 = 1'b1;
  logic berr_n, berr_n2;

  exp_t        exp_q[$];
  event        chk_ev;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  watchdog #(.TIMEOUT(100)) dut  (.clk(clk), .clr(clr),  .berr_n(berr_n));
  watchdog #(.TIMEOUT(1))   dut1 (.clk(clk), .clr(clr2), .berr_n(berr_n2));

  watchdog_if #(.CNT_W(7)) mon_if  ();
  watchdog_if #(.CNT_W(1)) mon1_if ();
  assign mon_if.cnt      = dut.cnt_if.cnt;
  assign mon_if.tc_next  = dut.cnt_if.tc_next;
  assign mon1_if.cnt     = dut1.cnt_if.cnt;
  assign mon1_if.tc_next = dut1.cnt_if.tc_next;

  always #1 clk = ~clk;

  task automatic wait_until(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic expect_state(input logic [63:0] tag, input logic d2,
                              input logic b, input int unsigned c);
    exp_t e;
    e.tag      = tag;
    e.dut2     = d2;
    e.exp_berr = b;
    e.exp_cnt  = 16'(c);
    exp_q.push_back(e);
    ->chk_ev;
  endtask

  initial begin : monitor
    exp_t        e;
    logic        act_b;
    logic [15:0] act_c;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        act_b = e.dut2 ? berr_n2 : berr_n;
        act_c = e.dut2 ? 16'(mon1_if.cnt) : 16'(mon_if.cnt);
        n_cmp++;
        if (act_b !== e.exp_berr) begin
          n_bad++;
          $display("FAIL %s berr_n t=%0t actual=%b required=%b", e.tag, $realtime, act_b, e.exp_berr);
        end
        n_cmp++;
        if (act_c !== e.exp_cnt) begin
          n_bad++;
          $display("FAIL %s cnt t=%0t actual=%0d required=%0d", e.tag, $realtime, act_c, e.exp_cnt);
        end
      end
    end
  end

  initial begin : stim_main
    realtime t0;
    int      n;
    wait_until(0.5);
    expect_state("PWRUP", 1'b0, 1'b1, 0);
    for (int m = 1; m <= 60; m++) begin
      wait_until(2.0 * m);
      expect_state("RUN", 1'b0, 1'b1, m);
    end

    wait_until(120.5);  clr = 1'b1;
    wait_until(120.75); expect_state("CLRASYNC", 1'b0, 1'b1, 0);
    wait_until(121.5);  clr = 1'b0;
    for (int m = 61; m <= 190; m++) begin
      n = m - 61;
      wait_until(2.0 * m);
      expect_state("TMO", 1'b0, n < 100, (n < 100) ? n : 100);
    end

    wait_until(380.5);  clr = 1'b1;
    wait_until(380.75); expect_state("KICKTMO", 1'b0, 1'b1, 0);
    for (int m = 191; m <= 210; m++) begin
      wait_until(2.0 * m);
      expect_state("HOLD", 1'b0, 1'b1, 0);
    end
    wait_until(420.5);  clr = 1'b0;
    for (int m = 211; m <= 310; m++) begin
      n = m - 210;
      wait_until(2.0 * m);
      expect_state("REL", 1'b0, n < 100, (n < 100) ? n : 100);
    end

    wait_until(620.5);  clr = 1'b1;
    wait_until(621.5);  clr = 1'b0;
    for (int m = 311; m <= 410; m++) begin
      wait_until(2.0 * m);
      expect_state("PRE", 1'b0, 1'b1, m - 311);
    end
    wait_until(820.9);  clr = 1'b1;
    wait_until(821.5);  clr = 1'b0;
    wait_until(822.0);  expect_state("COINC", 1'b0, 1'b1, 0);

    t0 = 821.5;
    for (int i = 0; i < 10; i++) begin
      for (int j = 1; j <= 98; j++) begin
        wait_until(t0 + 0.5 + 2.0 * j);
        expect_state("KICK", 1'b0, 1'b1, j);
      end
      wait_until(t0 + 197.0); clr = 1'b1;
      wait_until(t0 + 198.0); clr = 1'b0;
      t0 = t0 + 198.0;
    end

    for (int j = 1; j <= 101; j++) begin
      wait_until(t0 + 0.5 + 2.0 * j);
      expect_state("FINAL", 1'b0, j < 100, (j < 100) ? j : 100);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim_t1
    wait_until(4.0);   expect_state("T1HOLD", 1'b1, 1'b1, 0);
    wait_until(4.5);   clr2 = 1'b0;
    wait_until(6.0);   expect_state("T1TMO", 1'b1, 1'b0, 1);
    wait_until(8.0);   expect_state("T1STICK", 1'b1, 1'b0, 1);
    wait_until(8.5);   clr2 = 1'b1;
    wait_until(8.75);  expect_state("T1CLR", 1'b1, 1'b1, 0);
    wait_until(9.5);   clr2 = 1'b0;
    wait_until(10.0);  expect_state("T1IDLE", 1'b1, 1'b1, 0);
    wait_until(10.9);  clr2 = 1'b1;
    wait_until(11.5);  clr2 = 1'b0;
    wait_until(12.0);  expect_state("T1COINC", 1'b1, 1'b1, 0);
    wait_until(14.0);  expect_state("T1TMO2", 1'b1, 1'b0, 1);
  end

  initial begin : time_guard
    #200000;
    $display("FAIL time_guard actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
